// File: rtl/flash_spi_pkg.sv
// Opcodes, FSM state encoding and status bit positions shared by the SPI flash
// writer. The quad-mode reader is expected to adopt these opcode constants too.
package flash_spi_pkg;

  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_SE   = 8'h20;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_CRM  = 8'hFF;

  localparam int SR_WIP = 0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CRM,
    ST_GAP1,
    ST_WREN,
    ST_GAP2,
    ST_CMD,
    ST_GAP3,
    ST_POLL,
    ST_FIN,
    ST_DONE
  } wr_state_e;

  typedef enum logic {
    KIND_PROG,
    KIND_ERASE
  } op_kind_e;

endpackage

// File: rtl/spi_bit_shifter.sv
// Single-I/O SPI bit engine: divides clk by two while selected, shifts a
// left-aligned word out MSB first and collects MISO samples on falling edges.
module spi_bit_shifter (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        active_i,
  input  logic        load_i,
  input  logic [63:0] load_data_i,
  input  logic [6:0]  load_bits_i,
  input  logic        sdi_i,
  output logic        sclk_o,
  output logic        sdo_o,
  output logic        fall_o,
  output logic        last_bit_o,
  output logic [6:0]  bits_left_o,
  output logic [7:0]  rx_next_o
);

  logic        div_q;
  logic [63:0] tx_q;
  logic [6:0]  rx_q;
  logic [6:0]  cnt_q;

  assign sclk_o      = div_q;
  assign sdo_o       = tx_q[63];
  assign fall_o      = active_i & div_q;
  assign last_bit_o  = fall_o & (cnt_q == 7'd0);
  assign bits_left_o = cnt_q;
  // The byte as it will look once the current falling-edge sample lands.
  assign rx_next_o   = {rx_q, sdi_i};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      div_q <= 1'b0;
      tx_q  <= '0;
      rx_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      div_q <= 1'b0;
      tx_q  <= load_data_i;
      cnt_q <= load_bits_i - 7'd1;
    end else if (!active_i) begin
      div_q <= 1'b0;
    end else begin
      div_q <= ~div_q;
      if (div_q) begin
        tx_q <= {tx_q[62:0], 1'b0};
        rx_q <= rx_next_o[6:0];
        if (cnt_q != 7'd0) cnt_q <= cnt_q - 7'd1;
      end
    end
  end

endmodule

// File: rtl/spi_flash_writer.sv
// SPI flash programmer: continuous-mode reset, write enable, page program or
// sector erase, then status polling until the flash reports the write done.
module spi_flash_writer
  import flash_spi_pkg::*;
#(
  parameter int GAP_BITS = 4,
  parameter int POLL_MAX = 65535
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [23:0] address_i,
  input  logic [31:0] data_i,
  input  logic        start_write_i,
  input  logic        start_erase_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic        cs_o,
  output logic        spi_clk_o,
  output logic        write_o,
  output logic        io0_out_o,
  output logic        io2_out_o,
  output logic        io3_out_o,
  input  logic        io1_in_i
);

  localparam int GAP_CLKS = GAP_BITS * 2;
  localparam int GW = $clog2(GAP_CLKS + 1);
  localparam int PW = $clog2(POLL_MAX + 1);

  wr_state_e   state_q;
  op_kind_e    op_q;
  logic [23:0] addr_q;
  logic [31:0] data_q;
  logic        cs_q, write_q, busy_q, done_q, error_q;
  logic [GW-1:0] gap_q;
  logic [PW-1:0] poll_q;

  logic        ld_d;
  logic [63:0] ld_data_d;
  logic [6:0]  ld_bits_d;
  logic        fall, last_bit;
  logic [6:0]  bits_left;
  logic [7:0]  rx_byte;
  logic        gap_done, poll_at_max, accept;
  logic        unused_addr_hi, unused_status;

  assign accept         = start_write_i | start_erase_i;
  assign gap_done       = (gap_q == GW'(GAP_CLKS - 1));
  assign poll_at_max    = (poll_q == PW'(POLL_MAX - 1));
  assign unused_addr_hi = ^address_i[23:22];
  assign unused_status  = ^rx_byte;

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign error_o   = error_q;
  assign cs_o      = cs_q;
  assign write_o   = write_q;
  assign io2_out_o = 1'b1;
  assign io3_out_o = 1'b1;

  spi_bit_shifter u_shifter (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .active_i    (~cs_q),
    .load_i      (ld_d),
    .load_data_i (ld_data_d),
    .load_bits_i (ld_bits_d),
    .sdi_i       (io1_in_i),
    .sclk_o      (spi_clk_o),
    .sdo_o       (io0_out_o),
    .fall_o      (fall),
    .last_bit_o  (last_bit),
    .bits_left_o (bits_left),
    .rx_next_o   (rx_byte)
  );

  // Shifter loads coincide with the clk edge on which cs falls (or stays low
  // for another status byte), so the first bit is already on io0 at cs fall.
  always_comb begin
    ld_d      = 1'b0;
    ld_data_d = '0;
    ld_bits_d = '0;
    unique case (state_q)
      ST_IDLE: if (accept) begin
        ld_d = 1'b1; ld_data_d = {OP_CRM, 56'h0}; ld_bits_d = 7'd8;
      end
      ST_GAP1: if (gap_done) begin
        ld_d = 1'b1; ld_data_d = {OP_WREN, 56'h0}; ld_bits_d = 7'd8;
      end
      ST_GAP2: if (gap_done) begin
        ld_d = 1'b1;
        if (op_q == KIND_PROG) begin
          ld_data_d = {OP_PP, addr_q, data_q}; ld_bits_d = 7'd64;
        end else begin
          ld_data_d = {OP_SE, addr_q, 32'h0}; ld_bits_d = 7'd32;
        end
      end
      ST_GAP3: if (gap_done) begin
        ld_d = 1'b1; ld_data_d = {OP_RDSR, 56'h0}; ld_bits_d = 7'd16;
      end
      ST_POLL: if (last_bit && rx_byte[SR_WIP] && !poll_at_max) begin
        ld_d = 1'b1; ld_bits_d = 7'd8;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      op_q    <= KIND_PROG;
      addr_q  <= '0;
      data_q  <= '0;
      cs_q    <= 1'b1;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      gap_q   <= '0;
      poll_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: if (accept) begin
          op_q    <= start_write_i ? KIND_PROG : KIND_ERASE;
          addr_q  <= {address_i[21:0], 2'b00};
          data_q  <= data_i;
          busy_q  <= 1'b1;
          error_q <= 1'b0;
          cs_q    <= 1'b0;
          write_q <= 1'b1;
          poll_q  <= '0;
          state_q <= ST_CRM;
        end
        ST_CRM, ST_WREN, ST_CMD: if (last_bit) begin
          cs_q    <= 1'b1;
          write_q <= 1'b0;
          gap_q   <= '0;
          state_q <= (state_q == ST_CRM)  ? ST_GAP1 :
                     (state_q == ST_WREN) ? ST_GAP2 : ST_GAP3;
        end
        ST_GAP1, ST_GAP2, ST_GAP3: begin
          if (gap_done) begin
            cs_q    <= 1'b0;
            write_q <= 1'b1;
            state_q <= (state_q == ST_GAP1) ? ST_WREN :
                       (state_q == ST_GAP2) ? ST_CMD  : ST_POLL;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        // Only the first poll frame is 16 bits long, so 8 bits remaining
        // marks the end of the opcode and the start of the status read.
        ST_POLL: begin
          if (fall && bits_left == 7'd8) write_q <= 1'b0;
          if (last_bit) begin
            if (!rx_byte[SR_WIP]) begin
              cs_q    <= 1'b1;
              state_q <= ST_FIN;
            end else if (poll_at_max) begin
              error_q <= 1'b1;
              cs_q    <= 1'b1;
              state_q <= ST_FIN;
            end else begin
              poll_q <= poll_q + 1'b1;
            end
          end
        end
        ST_FIN: state_q <= ST_DONE;
        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_writer.sv
// Scoreboard bench for spi_flash_writer: a behavioural flash decodes MOSI and
// streams status bytes; monitors compare MOSI bytes and done pulses to queues.
module tb_spi_flash_writer;

  localparam int GAP_BITS = 4;
  localparam int POLL_MAX = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] address = '0;
  logic [31:0] data = '0;
  logic        startWrite = 1'b0;
  logic        startErase = 1'b0;
  logic        io1 = 1'b0;
  logic        busyO, doneO, errorO, csO, spiClkO, writeO, io0O, io2O, io3O;

  typedef struct {
    logic err;
    int   polls;
    int   lat;
    int   startCyc;
  } doneExp_t;

  logic [7:0] expBytes[$];
  doneExp_t   expDone[$];
  doneExp_t   doneSeen;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int gapLen = 0;
  int clkViol = 0, pinViol = 0, wrViol = 0;

  int         bitCnt = 0;
  int         statusReads = 0;
  logic [7:0] rxSh = '0;
  logic [7:0] frameOp = '0;
  logic [7:0] statSeq [0:15];
  int         statLen = 1;

  spi_flash_writer #(.GAP_BITS(GAP_BITS), .POLL_MAX(POLL_MAX)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .address_i     (address),
    .data_i        (data),
    .start_write_i (startWrite),
    .start_erase_i (startErase),
    .busy_o        (busyO),
    .done_o        (doneO),
    .error_o       (errorO),
    .cs_o          (csO),
    .spi_clk_o     (spiClkO),
    .write_o       (writeO),
    .io0_out_o     (io0O),
    .io2_out_o     (io2O),
    .io3_out_o     (io3O),
    .io1_in_i      (io1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic expectBytes(input logic [95:0] v, input int n);
    for (int i = 0; i < n; i++) expBytes.push_back(v[95 - 8*i -: 8]);
  endtask

  task automatic applyStimulus(input bit w, input bit e, input logic [23:0] a,
                               input logic [31:0] d, input bit wantDone,
                               input logic err, input int polls, input int lat);
    doneExp_t x;
    @(negedge clk);
    address = a; data = d; startWrite = w; startErase = e;
    if (wantDone) begin
      x.err = err; x.polls = polls; x.lat = lat; x.startCyc = cyc;
      expDone.push_back(x);
    end
    @(negedge clk);
    startWrite = 1'b0; startErase = 1'b0;
    checkOutput("busy after accept", busyO, 1);
    checkOutput("error cleared on accept", errorO, 0);
  endtask

  task automatic waitDone();
    for (int i = 0; i < 3000 && expDone.size() > 0; i++) @(negedge clk);
    checkOutput("done timeout", expDone.size(), 0);
    checkOutput("mosi bytes consumed", expBytes.size(), 0);
    expDone.delete();
    expBytes.delete();
    repeat (4) @(negedge clk);
  endtask

  // Flash model: new frame on cs fall, MOSI sampled on spi_clk rise.
  always @(negedge csO) begin
    bitCnt = 0;
    frameOp = 8'h00;
    statusReads = 0;
  end

  always @(posedge spiClkO) begin
    if (!csO) begin
      if (frameOp == 8'h05 && bitCnt >= 8 && writeO) wrViol++;
      rxSh = {rxSh[6:0], io0O};
      bitCnt++;
      if (bitCnt % 8 == 0) begin
        if (bitCnt == 8) frameOp = rxSh;
        if (writeO) begin
          if (expBytes.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL mosi byte: got %02h, required none", rxSh);
          end else begin
            checkOutput("mosi byte", rxSh, expBytes.pop_front());
          end
        end else if (frameOp == 8'h05) begin
          statusReads++;
        end
      end
    end
  end

  // Status bits change after spi_clk falls, ahead of the next falling sample.
  always @(negedge spiClkO) begin
    if (!csO && frameOp == 8'h05 && bitCnt >= 8) begin
      int r, idx;
      r = bitCnt - 8;
      idx = r / 8;
      if (idx >= statLen) idx = statLen - 1;
      io1 = statSeq[idx][7 - (r % 8)];
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (csO && spiClkO) clkViol++;
      if (!io2O || !io3O) pinViol++;
      if (busyO && csO) begin
        gapLen++;
      end else begin
        if (busyO && gapLen > 0) checkOutput("cs gap clk", gapLen, 2 * GAP_BITS);
        gapLen = 0;
      end
      if (doneO) begin
        if (expDone.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL done pulse: got 1, required 0");
        end else begin
          doneSeen = expDone.pop_front();
          checkOutput("done error flag", errorO, doneSeen.err);
          checkOutput("done cs high", csO, 1);
          checkOutput("done busy low", busyO, 0);
          checkOutput("status bytes read", statusReads, doneSeen.polls);
          checkOutput("latency clk", cyc - doneSeen.startCyc - 1, doneSeen.lat);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) statSeq[i] = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset outputs", {csO, spiClkO, writeO, io0O, busyO, doneO, errorO}, 7'b1000000);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle outputs", {csO, spiClkO, writeO, busyO, doneO, errorO, io2O, io3O}, 8'b10000011);

    $display("[TB] program, WIP clear on first read");
    statSeq[0] = 8'h00; statLen = 1;
    expectBytes(96'hFF0602000100DEADBEEF0500, 11);
    applyStimulus(1, 0, 24'h000040, 32'hDEADBEEF, 1, 0, 1, 218);
    waitDone();

    $display("[TB] program, status 03 03 00");
    statSeq[0] = 8'h03; statSeq[1] = 8'h03; statSeq[2] = 8'h00; statLen = 3;
    expectBytes(96'hFF0602000100DEADBEEF0500, 11);
    applyStimulus(1, 0, 24'h000040, 32'hDEADBEEF, 1, 0, 3, 250);
    waitDone();

    $display("[TB] erase, WIP set for 10 reads");
    for (int i = 0; i < 10; i++) statSeq[i] = 8'h01;
    statSeq[10] = 8'h00; statLen = 11;
    expectBytes(96'hFF0620001000050000000000, 7);
    applyStimulus(0, 1, 24'h000400, 32'h0, 1, 0, 11, 314);
    repeat (200) @(negedge clk);
    checkOutput("busy while WIP", busyO, 1);
    waitDone();

    $display("[TB] poll timeout, WIP stuck");
    statSeq[0] = 8'h01; statLen = 1;
    expectBytes(96'hFF060208D158012345670500, 11);
    applyStimulus(1, 0, 24'hC23456, 32'h01234567, 1, 1, POLL_MAX, 394);
    waitDone();
    checkOutput("error sticky", errorO, 1);

    $display("[TB] priority and ignored request");
    statSeq[0] = 8'h00; statLen = 1;
    expectBytes(96'hFF0602000100CAFEF00D0500, 11);
    applyStimulus(1, 1, 24'h000040, 32'hCAFEF00D, 1, 0, 1, 218);
    repeat (100) @(negedge clk);
    startErase = 1'b1;
    @(negedge clk);
    startErase = 1'b0;
    waitDone();

    $display("[TB] async reset during command");
    expectBytes(96'hFF0602000100000000000000, 5);
    applyStimulus(1, 0, 24'h000040, 32'h12345678, 0, 0, 0, 0);
    for (int i = 0; i < 1000 && expBytes.size() > 0; i++) @(negedge clk);
    checkOutput("bytes before abort", expBytes.size(), 0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 checkOutput("reset mid command", {csO, spiClkO, busyO}, 3'b100);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    expBytes.delete();
    expectBytes(96'hFF0602000100DEADBEEF0500, 11);
    applyStimulus(1, 0, 24'h000040, 32'hDEADBEEF, 1, 0, 1, 218);
    waitDone();

    checkOutput("spi_clk while deselected", clkViol, 0);
    checkOutput("io2 io3 held high", pinViol, 0);
    checkOutput("write during status read", wrViol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
